// File: rtl/mul_sequencer.sv
// Iterative shift-add multiplier for MUL/UMULL/SMULL, one multiplier bit per cycle,
// writing the product back low word first, then high word for long multiplies.
module mul_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             start,
  input  logic             IsLongMul,
  input  logic             IsSigned,
  input  logic [WIDTH-1:0] SrcA,
  input  logic [WIDTH-1:0] SrcB,
  input  logic [3:0]       RdLo,
  input  logic [3:0]       RdHi,
  output logic             busy,
  output logic             done,
  output logic             WriteEn,
  output logic [3:0]       WriteAddr,
  output logic [WIDTH-1:0] WriteData,
  output logic [2:0]       state
);

  localparam int unsigned PW   = 2 * WIDTH;
  localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

  localparam logic [2:0] StIdle = 3'd0;
  localparam logic [2:0] StCalc = 3'd1;
  localparam logic [2:0] StWbLo = 3'd2;
  localparam logic [2:0] StWbHi = 3'd3;
  localparam logic [2:0] StDone = 3'd4;

  logic [2:0]       state_q, state_d;
  logic [CntW-1:0]  count_q, count_d;
  logic [PW-1:0]    acc_q, acc_d;
  logic [PW-1:0]    mcand_q, mcand_d;
  logic [WIDTH-1:0] mplr_q, mplr_d;
  logic             neg_q, neg_d;
  logic             long_q, long_d;
  logic [3:0]       rdlo_q, rdlo_d;
  logic [3:0]       rdhi_q, rdhi_d;

  logic             sgn;
  logic [WIDTH-1:0] a_abs, b_abs;
  logic [PW-1:0]    sum;

  // Signed mode works on magnitudes; the sign is reapplied once at the end of CALC.
  assign sgn   = IsLongMul & IsSigned;
  assign a_abs = (sgn && SrcA[WIDTH-1]) ? (~SrcA + WIDTH'(1)) : SrcA;
  assign b_abs = (sgn && SrcB[WIDTH-1]) ? (~SrcB + WIDTH'(1)) : SrcB;
  assign sum   = acc_q + (mplr_q[0] ? mcand_q : '0);

  always_comb begin
    state_d = state_q;
    count_d = count_q;
    acc_d   = acc_q;
    mcand_d = mcand_q;
    mplr_d  = mplr_q;
    neg_d   = neg_q;
    long_d  = long_q;
    rdlo_d  = rdlo_q;
    rdhi_d  = rdhi_q;
    case (state_q)
      StIdle: begin
        if (start) begin
          state_d = StCalc;
          count_d = '0;
          acc_d   = '0;
          mcand_d = {{WIDTH{1'b0}}, a_abs};
          mplr_d  = b_abs;
          neg_d   = sgn & (SrcA[WIDTH-1] ^ SrcB[WIDTH-1]);
          long_d  = IsLongMul;
          rdlo_d  = RdLo;
          rdhi_d  = RdHi;
        end
      end
      StCalc: begin
        acc_d   = sum;
        mcand_d = mcand_q << 1;
        mplr_d  = mplr_q >> 1;
        count_d = count_q + CntW'(1);
        if (count_q == LastCnt) begin
          state_d = StWbLo;
          count_d = '0;
          if (neg_q) acc_d = ~sum + PW'(1);
        end
      end
      StWbLo:  state_d = long_q ? StWbHi : StDone;
      StWbHi:  state_d = StDone;
      StDone:  state_d = StIdle;
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!reset) begin
      state_q <= StIdle;
      count_q <= '0;
      acc_q   <= '0;
      mcand_q <= '0;
      mplr_q  <= '0;
      neg_q   <= 1'b0;
      long_q  <= 1'b0;
      rdlo_q  <= '0;
      rdhi_q  <= '0;
    end else begin
      state_q <= state_d;
      count_q <= count_d;
      acc_q   <= acc_d;
      mcand_q <= mcand_d;
      mplr_q  <= mplr_d;
      neg_q   <= neg_d;
      long_q  <= long_d;
      rdlo_q  <= rdlo_d;
      rdhi_q  <= rdhi_d;
    end
  end

  always_comb begin
    busy      = (state_q != StIdle);
    done      = (state_q == StDone);
    WriteEn   = 1'b0;
    WriteAddr = '0;
    WriteData = '0;
    if (state_q == StWbLo) begin
      WriteEn   = 1'b1;
      WriteAddr = rdlo_q;
      WriteData = acc_q[WIDTH-1:0];
    end else if (state_q == StWbHi) begin
      WriteEn   = 1'b1;
      WriteAddr = rdhi_q;
      WriteData = acc_q[PW-1:WIDTH];
    end
  end

  assign state = state_q;

endmodule

// File: tb/tb_mul_sequencer.sv
// Self-checking bench for mul_sequencer: directed cases plus random operations scored
// against a plain-arithmetic 64-bit product model.
module tb_mul_sequencer;

  localparam int W = 32;

  logic          clk = 1'b0;
  logic          reset, start, IsLongMul, IsSigned;
  logic [W-1:0]  SrcA, SrcB;
  logic [3:0]    RdLo, RdHi;
  logic          busy, done, WriteEn;
  logic [3:0]    WriteAddr;
  logic [W-1:0]  WriteData;
  logic [2:0]    state;

  int checks = 0;
  int failures = 0;

  // Observations from the most recent operation.
  int           nwr, done_cyc, done_cnt;
  logic [3:0]   wr_addr[4];
  logic [W-1:0] wr_data[4];
  int           wr_cyc[4];

  mul_sequencer #(.WIDTH(W)) dut (
    .clk(clk), .reset(reset), .start(start), .IsLongMul(IsLongMul), .IsSigned(IsSigned),
    .SrcA(SrcA), .SrcB(SrcB), .RdLo(RdLo), .RdHi(RdHi), .busy(busy), .done(done),
    .WriteEn(WriteEn), .WriteAddr(WriteAddr), .WriteData(WriteData), .state(state)
  );

  always #5 clk = ~clk;

  function automatic logic [63:0] model(input logic lng, input logic sgn,
                                        input logic [31:0] a, input logic [31:0] b);
    longint sa, sb;
    if (lng && sgn) begin
      sa = $signed(a);
      sb = $signed(b);
      return 64'(sa * sb);
    end
    return {32'b0, a} * {32'b0, b};
  endfunction

  // Runs one operation for a fixed 60-cycle window, recording writes and done pulses.
  // Inputs are scrambled after start to show they are not re-sampled.
  task automatic do_op(input logic lng, input logic sgn, input logic [31:0] a,
                       input logic [31:0] b, input logic [3:0] lo, input logic [3:0] hi,
                       input int repulse_at);
    nwr = 0; done_cyc = -1; done_cnt = 0;
    IsLongMul = lng; IsSigned = sgn; SrcA = a; SrcB = b; RdLo = lo; RdHi = hi;
    start = 1'b1;
    for (int n = 1; n <= 60; n++) begin
      @(posedge clk); #1;
      start = (n == repulse_at);
      SrcA = $urandom; SrcB = $urandom; RdLo = 4'($urandom); RdHi = 4'($urandom);
      IsLongMul = 1'($urandom); IsSigned = 1'($urandom);
      if (WriteEn) begin
        if (nwr < 4) begin
          wr_addr[nwr] = WriteAddr; wr_data[nwr] = WriteData; wr_cyc[nwr] = n;
        end
        nwr++;
      end
      if (done) begin
        done_cnt++;
        if (done_cyc < 0) done_cyc = n;
      end
    end
    start = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b0; start = 1'b0; IsLongMul = 1'b0; IsSigned = 1'b0;
    SrcA = '0; SrcB = '0; RdLo = '0; RdHi = '0;
    repeat (3) @(posedge clk);
    #1;
    checks++;
    if ({state, busy, done, WriteEn, WriteAddr, WriteData} !== '0) begin
      failures++;
      $display("FAIL reset_outputs got state=%0d busy=%b done=%b we=%b wa=%0d wd=%h want all 0",
               state, busy, done, WriteEn, WriteAddr, WriteData);
    end
    reset = 1'b1;
    @(posedge clk); #1;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0) begin
      failures++;
      $display("FAIL idle_after_reset got state=%0d busy=%b want 0/0", state, busy);
    end
  endtask

  task automatic test_mul_basic();
    do_op(1'b0, 1'b0, 32'd7, 32'd6, 4'd2, 4'd9, 0);
    checks++;
    if (nwr !== 1 || wr_addr[0] !== 4'd2 || wr_data[0] !== 32'd42) begin
      failures++;
      $display("FAIL mul_7x6 got nwr=%0d r%0d=%0d want nwr=1 r2=42", nwr, wr_addr[0], wr_data[0]);
    end
    checks++;
    if (done_cyc !== 34 || done_cnt !== 1) begin
      failures++;
      $display("FAIL mul_latency got done_cyc=%0d cnt=%0d want 34/1", done_cyc, done_cnt);
    end
    checks++;
    if (wr_cyc[0] !== 33) begin
      failures++;
      $display("FAIL mul_wblo_cycle got %0d want 33", wr_cyc[0]);
    end
  endtask

  task automatic test_umull_max();
    do_op(1'b1, 1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 4'd4, 4'd5, 0);
    checks++;
    if (nwr !== 2 || wr_addr[0] !== 4'd4 || wr_data[0] !== 32'h1 ||
        wr_addr[1] !== 4'd5 || wr_data[1] !== 32'hFFFF_FFFE) begin
      failures++;
      $display("FAIL umull_max got nwr=%0d r%0d=%h r%0d=%h want r4=00000001 r5=fffffffe",
               nwr, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
    checks++;
    if (done_cyc !== 35 || done_cnt !== 1) begin
      failures++;
      $display("FAIL umull_latency got done_cyc=%0d cnt=%0d want 35/1", done_cyc, done_cnt);
    end
  endtask

  task automatic test_smull();
    do_op(1'b1, 1'b1, 32'hFFFF_FFFE, 32'd3, 4'd0, 4'd1, 0);
    checks++;
    if (nwr !== 2 || wr_data[0] !== 32'hFFFF_FFFA || wr_data[1] !== 32'hFFFF_FFFF) begin
      failures++;
      $display("FAIL smull_m2x3 got nwr=%0d lo=%h hi=%h want fffffffa/ffffffff",
               nwr, wr_data[0], wr_data[1]);
    end
    do_op(1'b1, 1'b1, 32'h8000_0000, 32'h8000_0000, 4'd6, 4'd7, 0);
    checks++;
    if (nwr !== 2 || wr_data[0] !== 32'h0 || wr_data[1] !== 32'h4000_0000) begin
      failures++;
      $display("FAIL smull_min_sq got nwr=%0d lo=%h hi=%h want 00000000/40000000",
               nwr, wr_data[0], wr_data[1]);
    end
  endtask

  task automatic test_repulse();
    do_op(1'b1, 1'b0, 32'd1000, 32'd3000, 4'd8, 4'd9, 10);
    checks++;
    if (done_cnt !== 1 || nwr !== 2 || wr_data[0] !== 32'd3000000 || wr_data[1] !== 32'd0 ||
        wr_addr[0] !== 4'd8 || wr_addr[1] !== 4'd9) begin
      failures++;
      $display("FAIL repulse got done_cnt=%0d nwr=%0d r%0d=%0d r%0d=%0d want 1/2 r8=3000000 r9=0",
               done_cnt, nwr, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_reset_mid();
    int writes;
    IsLongMul = 1'b1; IsSigned = 1'b0; SrcA = 32'd3; SrcB = 32'd3; RdLo = 4'd1; RdHi = 4'd2;
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0;
    repeat (10) @(posedge clk);
    #1;
    reset = 1'b0;
    @(posedge clk); #1;
    reset = 1'b1;
    checks++;
    if (state !== 3'd0 || busy !== 1'b0 || WriteEn !== 1'b0 || done !== 1'b0) begin
      failures++;
      $display("FAIL reset_mid got state=%0d busy=%b we=%b done=%b want 0/0/0/0",
               state, busy, WriteEn, done);
    end
    writes = 0;
    for (int n = 0; n < 40; n++) begin
      @(posedge clk); #1;
      if (WriteEn) writes++;
    end
    checks++;
    if (writes !== 0) begin
      failures++;
      $display("FAIL reset_mid_nowrite got writes=%0d want 0", writes);
    end
    do_op(1'b0, 1'b0, 32'd5, 32'd5, 4'd11, 4'd0, 0);
    checks++;
    if (nwr !== 1 || wr_addr[0] !== 4'd11 || wr_data[0] !== 32'd25) begin
      failures++;
      $display("FAIL after_reset_5x5 got nwr=%0d r%0d=%0d want 1 r11=25", nwr, wr_addr[0], wr_data[0]);
    end
  endtask

  task automatic test_same_rd();
    do_op(1'b1, 1'b0, 32'h0001_0000, 32'h0001_0000, 4'd3, 4'd3, 0);
    checks++;
    if (nwr !== 2 || wr_addr[0] !== 4'd3 || wr_addr[1] !== 4'd3 ||
        wr_data[0] !== 32'h0 || wr_data[1] !== 32'h1) begin
      failures++;
      $display("FAIL same_rd got nwr=%0d r%0d=%h r%0d=%h want r3=0 then r3=1",
               nwr, wr_addr[0], wr_data[0], wr_addr[1], wr_data[1]);
    end
  endtask

  task automatic test_random();
    logic         lng, sgn;
    logic [31:0]  a, b;
    logic [3:0]   lo, hi;
    logic [63:0]  exp;
    int           exp_n;
    for (int i = 0; i < 20; i++) begin
      lng = 1'($urandom); sgn = 1'($urandom);
      a = $urandom; b = $urandom;
      if (i % 5 == 0) a = '0;
      if (i % 7 == 3) b = '0;
      lo = 4'($urandom); hi = 4'($urandom);
      exp = model(lng, sgn, a, b);
      exp_n = lng ? 2 : 1;
      do_op(lng, sgn, a, b, lo, hi, (i % 3 == 0) ? 5 + i : 0);
      checks++;
      if (nwr !== exp_n || wr_addr[0] !== lo || wr_data[0] !== exp[31:0] ||
          (lng && (wr_addr[1] !== hi || wr_data[1] !== exp[63:32]))) begin
        failures++;
        $display("FAIL random_%0d a=%h b=%h lng=%b sgn=%b got nwr=%0d lo=%h hi=%h want %0d %h",
                 i, a, b, lng, sgn, nwr, wr_data[0], wr_data[1], exp_n, exp);
      end
      checks++;
      if (done_cyc !== (lng ? 35 : 34) || done_cnt !== 1) begin
        failures++;
        $display("FAIL random_latency_%0d got done_cyc=%0d cnt=%0d want %0d/1",
                 i, done_cyc, done_cnt, lng ? 35 : 34);
      end
    end
  endtask

  initial begin
    test_reset();
    test_mul_basic();
    test_umull_max();
    test_smull();
    test_repulse();
    test_reset_mid();
    test_same_rd();
    test_random();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
